// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes, register IDs and word width
package y86_pkg;
    localparam int WORD_W = 64;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RRSP    = 4'h4;
    localparam logic [3:0] RNONE   = 4'hF;
endpackage

// File: rtl/writeback_if.sv
// writeback_if: instruction fields, data values, decoded destinations and debug read port
interface writeback_if;
    import y86_pkg::*;
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              cnd;
    logic [WORD_W-1:0] valE;
    logic [WORD_W-1:0] valM;
    logic [WORD_W-1:0] valA;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [3:0]        dbg_addr;
    logic [WORD_W-1:0] dbg_data;
    modport master (
        output icode, rA, rB, cnd, valE, valM, valA, dbg_addr,
        input  dstE, dstM, dbg_data
    );
    modport slave (
        input  icode, rA, rB, cnd, valE, valM, valA, dbg_addr,
        output dstE, dstM, dbg_data
    );
endinterface

// File: rtl/y86_regfile.sv
// y86_regfile: 15x64 register file, E and M write ports (M wins), one combinational read port
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [WORD_W-1:0] RSP_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        dst_e,
    input  logic [WORD_W-1:0] val_e,
    input  logic [3:0]        dst_m,
    input  logic [WORD_W-1:0] val_m,
    input  logic [3:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] regs [15];

    // Commit both ports each edge; M is written last so it wins on a shared destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs[i] <= (i == int'(RRSP)) ? RSP_RESET : '0;
        end else begin
            if (dst_e != RNONE) regs[dst_e] <= val_e;
            if (dst_m != RNONE) regs[dst_m] <= val_m;
        end
    end

    // Debug read; F is not a register and reads as zero
    always_comb rd_data = (rd_addr == RNONE) ? '0 : regs[rd_addr];
endmodule

// File: rtl/writeback.sv
// writeback: decodes dstE/dstM for the Y86-64 write-back stage and commits into the register file
module writeback
    import y86_pkg::*;
#(
    parameter logic [WORD_W-1:0] RSP_RESET = 64'd0
) (
    input logic       clk,
    input logic       rst_n,
    writeback_if.slave bus
);
    // E destination: conditional move, immediate/ALU writes to rB, stack ops update %rsp
    always_comb begin
        bus.dstE = (bus.icode == IRRMOVQ) ? (bus.cnd ? bus.rB : RNONE) :
                   (bus.icode == IIRMOVQ || bus.icode == IOPQ) ? bus.rB :
                   (bus.icode == ICALL || bus.icode == IRET ||
                    bus.icode == IPUSHQ || bus.icode == IPOPQ) ? RRSP : RNONE;
    end

    // M destination: memory loads land in rA
    always_comb begin
        bus.dstM = (bus.icode == IMRMOVQ || bus.icode == IPOPQ) ? bus.rA : RNONE;
    end

    y86_regfile #(.RSP_RESET(RSP_RESET)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .dst_e   (bus.dstE),
        .val_e   (bus.valE),
        .dst_m   (bus.dstM),
        .val_m   (bus.valM),
        .rd_addr (bus.dbg_addr),
        .rd_data (bus.dbg_data)
    );
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed checks of dst decode, register commits, collision and async reset
module tb_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    writeback_if bus();

    writeback #(.RSP_RESET(64'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [63:0] exp, input string tag);
        bus.dbg_addr = a;
        #1;
        chk(tag, bus.dbg_data, exp);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm);
        bus.icode = ic;
        bus.rA    = ra;
        bus.rB    = rb;
        bus.cnd   = c;
        bus.valE  = ve;
        bus.valM  = vm;
        bus.valA  = 64'hDEAD;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.dbg_addr = 4'h0;
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        #12;
        chk("nop_dstE", {60'd0, bus.dstE}, 64'hF);
        chk("nop_dstM", {60'd0, bus.dstM}, 64'hF);
        step();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) rd(4'(a), 64'd0, "reset_read");

        drive(4'hB, 4'h0, 4'h1, 1'b0, 64'd20, 64'd50);
        bus.valA = 64'd30;
        #1;
        chk("popq_dstE", {60'd0, bus.dstE}, 64'h4);
        chk("popq_dstM", {60'd0, bus.dstM}, 64'h0);
        step();
        rd(4'h4, 64'd20, "popq_r4");
        rd(4'h0, 64'd50, "popq_r0");
        rd(4'h1, 64'd0, "popq_r1");

        drive(4'h2, 4'hF, 4'h3, 1'b0, 64'd100, 64'd0);
        chk("cmov0_dstE", {60'd0, bus.dstE}, 64'hF);
        step();
        rd(4'h3, 64'd0, "cmov0_r3");
        drive(4'h2, 4'hF, 4'h3, 1'b1, 64'd100, 64'd0);
        chk("cmov1_dstE", {60'd0, bus.dstE}, 64'h3);
        step();
        rd(4'h3, 64'd100, "cmov1_r3");

        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'd256, 64'd0);
        step();
        rd(4'h5, 64'd256, "irmovq_r5");
        drive(4'h6, 4'hF, 4'h5, 1'b0, 64'd1024, 64'd0);
        step();
        rd(4'h5, 64'd1024, "opq_r5");
        drive(4'h3, 4'hF, 4'hF, 1'b0, 64'd5555, 64'd6666);
        chk("irmovq_rbF_dstE", {60'd0, bus.dstE}, 64'hF);
        step();
        drive(4'h6, 4'hF, 4'hF, 1'b0, 64'd7777, 64'd6666);
        step();
        rd(4'h5, 64'd1024, "rbF_r5");
        rd(4'h3, 64'd100, "rbF_r3");
        rd(4'hE, 64'd0, "rbF_r14");

        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd8, 64'd77);
        chk("coll_dstE", {60'd0, bus.dstE}, 64'h4);
        chk("coll_dstM", {60'd0, bus.dstM}, 64'h4);
        step();
        rd(4'h4, 64'd77, "coll_r4");

        drive(4'h5, 4'h7, 4'h1, 1'b1, 64'd900, 64'd51);
        chk("mrmovq_dstE", {60'd0, bus.dstE}, 64'hF);
        step();
        rd(4'h7, 64'd51, "mrmovq_r7");
        rd(4'h1, 64'd0, "mrmovq_r1");
        drive(4'h5, 4'hF, 4'h7, 1'b1, 64'd901, 64'd902);
        step();
        rd(4'h7, 64'd51, "mrmovq_raF_r7");

        drive(4'h4, 4'h1, 4'h2, 1'b1, 64'd999, 64'd999);
        chk("rmmovq_dstE", {60'd0, bus.dstE}, 64'hF);
        chk("rmmovq_dstM", {60'd0, bus.dstM}, 64'hF);
        step();
        drive(4'h7, 4'h1, 4'h2, 1'b1, 64'd999, 64'd999);
        chk("jxx_dstE", {60'd0, bus.dstE}, 64'hF);
        step();
        rd(4'h1, 64'd0, "illegal_r1");
        rd(4'h2, 64'd0, "illegal_r2");
        for (int ic = 12; ic < 16; ic++) begin
            drive(4'(ic), 4'h1, 4'h2, 1'b1, 64'd1, 64'd2);
            chk("unused_dstE", {60'd0, bus.dstE}, 64'hF);
            chk("unused_dstM", {60'd0, bus.dstM}, 64'hF);
        end
        drive(4'h0, 4'h1, 4'h2, 1'b1, 64'd1, 64'd2);
        chk("halt_dstE", {60'd0, bus.dstE}, 64'hF);
        drive(4'h8, 4'h1, 4'h2, 1'b0, 64'd3, 64'd4);
        chk("call_dstE", {60'd0, bus.dstE}, 64'h4);
        drive(4'hA, 4'h1, 4'h2, 1'b0, 64'd3, 64'd4);
        chk("push_dstM", {60'd0, bus.dstM}, 64'hF);

        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'd99, 64'd0);
        step();
        rd(4'h2, 64'd99, "pre_reset_r2");
        rst_n = 1'b0;
        rd(4'h2, 64'd0, "async_r2");
        rd(4'h7, 64'd0, "async_r7");
        rd(4'h4, 64'd0, "async_r4");
        step();
        rd(4'h2, 64'd0, "held_reset_r2");
        rst_n = 1'b1;
        rd(4'h5, 64'd0, "post_reset_r5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
